// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion datapath.
// Coordinates are unsigned 10-bit; velocities are signed 5-bit.
package sprite_pkg;

    localparam int COORD_W   = 10;
    localparam int VEL_W     = 5;
    localparam int CALC_W    = 11;
    localparam int X_MAX_DEF = 639;
    localparam int Y_MAX_DEF = 479;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sprite_bounce_alu.sv
// One-axis bounce step: advance position by velocity, clamp to [0, limit-SIZE+1]
// and reflect the velocity away from whichever wall was hit.
module sprite_bounce_alu
    import sprite_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  logic        [COORD_W-1:0] pos,
    input  logic signed [VEL_W-1:0]   vel,
    input  logic        [COORD_W-1:0] limit,
    output logic        [COORD_W-1:0] next_pos,
    output logic signed [VEL_W-1:0]   next_vel
);

    localparam logic signed [CALC_W-1:0] SPAN = CALC_W'(SIZE - 1);

    logic signed [CALC_W-1:0] sum;
    logic signed [CALC_W-1:0] lim_s;
    logic signed [VEL_W-1:0]  mag;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        next_pos = pos;
        next_vel = vel;
        sum      = $signed({1'b0, pos}) + $signed({{(CALC_W - VEL_W){vel[VEL_W-1]}}, vel});
        lim_s    = $signed({1'b0, limit});

        // Magnitude of the most negative velocity does not fit; pin it to +15.
        mag = vel[VEL_W-1] ? (~vel + 5'sd1) : vel;
        if (mag[VEL_W-1]) begin
            mag = 5'sd15;
        end

        if (sum < 0) begin
            next_pos = '0;
            next_vel = mag;
        end else if (sum + SPAN > lim_s) begin
            next_pos = limit - COORD_W'(SIZE - 1);
            next_vel = -mag;
        end else begin
            next_pos = sum[COORD_W-1:0];
        end
    end

endmodule

// File: rtl/sprite_motion_sequencer.sv
// Per-frame sweep over N sprites through one shared pair of bounce ALUs,
// with a valid/ready port for changing sprite velocities between sweeps.
module sprite_motion_sequencer
    import sprite_pkg::*;
#(
    parameter int N_SPRITES = 4,
    parameter int X_MAX     = X_MAX_DEF,
    parameter int Y_MAX     = Y_MAX_DEF,
    parameter int SIZE      = 64,
    parameter int SPEED     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_tick,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic        [2:0]              cfg_id,
    input  logic signed [VEL_W-1:0]        cfg_dx,
    input  logic signed [VEL_W-1:0]        cfg_dy,
    output logic [COORD_W*N_SPRITES-1:0]   pos_x,
    output logic [COORD_W*N_SPRITES-1:0]   pos_y,
    output logic                           busy,
    output logic                           done,
    output logic                           overrun
);

    localparam int IDX_W = $clog2(N_SPRITES);

    state_t                    state, state_next;
    logic [IDX_W-1:0]          idx, idx_next;

    logic        [COORD_W-1:0] x_q  [N_SPRITES];
    logic        [COORD_W-1:0] y_q  [N_SPRITES];
    logic signed [VEL_W-1:0]   dx_q [N_SPRITES];
    logic signed [VEL_W-1:0]   dy_q [N_SPRITES];

    logic        [COORD_W-1:0] nx_q, ny_q, alu_x, alu_y;
    logic signed [VEL_W-1:0]   ndx_q, ndy_q, alu_dx, alu_dy;
    logic                      cfg_fire, cfg_hit;

    sprite_bounce_alu #(.SIZE(SIZE)) u_alu_x (
        .pos      (x_q[idx]),
        .vel      (dx_q[idx]),
        .limit    (COORD_W'(X_MAX)),
        .next_pos (alu_x),
        .next_vel (alu_dx)
    );

    sprite_bounce_alu #(.SIZE(SIZE)) u_alu_y (
        .pos      (y_q[idx]),
        .vel      (dy_q[idx]),
        .limit    (COORD_W'(Y_MAX)),
        .next_pos (alu_y),
        .next_vel (alu_dy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_next = ST_CALC;
                    idx_next   = '0;
                end
            end
            ST_CALC:  state_next = ST_WRITE;
            ST_WRITE: begin
                if (idx == IDX_W'(N_SPRITES - 1)) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next   = idx + 1'b1;
                    state_next = ST_CALC;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign cfg_ready = (state == ST_IDLE) && !frame_tick;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_hit   = ({1'b0, cfg_id} < 4'(N_SPRITES));

    // NOTE: the sprite register file is reset because its reset contents are the
    // defined start-of-game layout, and a mid-sweep reset must discard partial writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                x_q[i]  <= COORD_W'(i * (SIZE + 16));
                y_q[i]  <= COORD_W'(i * 32);
                dx_q[i] <= VEL_W'(SPEED);
                dy_q[i] <= (i % 2 == 0) ? VEL_W'(SPEED) : VEL_W'(-SPEED);
            end
            nx_q  <= '0;
            ny_q  <= '0;
            ndx_q <= '0;
            ndy_q <= '0;
        end else begin
            if (state == ST_CALC) begin
                nx_q  <= alu_x;
                ny_q  <= alu_y;
                ndx_q <= alu_dx;
                ndy_q <= alu_dy;
            end
            if (state == ST_WRITE) begin
                x_q[idx]  <= nx_q;
                y_q[idx]  <= ny_q;
                dx_q[idx] <= ndx_q;
                dy_q[idx] <= ndy_q;
            end
            // Config only fires in IDLE, so it never collides with a write-back.
            if (cfg_fire && cfg_hit) begin
                dx_q[cfg_id[IDX_W-1:0]] <= cfg_dx;
                dy_q[cfg_id[IDX_W-1:0]] <= cfg_dy;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (frame_tick && state != ST_IDLE) begin
            overrun <= 1'b1;
        end
    end

    for (genvar i = 0; i < N_SPRITES; i++) begin : g_flat
        assign pos_x[COORD_W*i +: COORD_W] = x_q[i];
        assign pos_y[COORD_W*i +: COORD_W] = y_q[i];
    end

endmodule

// File: doc/sprite_motion_sequencer.md
Name: sprite_motion_sequencer

Overview:
Owns position and velocity state for N bouncing sprites and time-shares one bounce/collision datapath across them. On each frame tick it sweeps every sprite sequentially: next position, edge clamp, velocity reflection, write-back. It sits between the VGA timing controller (frame tick) and the pixel generator (flattened sprite positions). A valid/ready configuration port lets control logic (buttons, UART) change per-sprite velocity between sweeps.

Parameters:
N_SPRITES, 4, number of sprites, 2..8
X_MAX, 639, rightmost visible column
Y_MAX, 479, bottom visible row
SIZE, 64, sprite side length in pixels
SPEED, 2, reset velocity magnitude, 1..15

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high
frame_tick  in  1  one-cycle pulse per frame, issued in vertical blank
cfg_valid  in  1  configuration request
cfg_ready  out  1  configuration accepted this cycle when valid&ready
cfg_id  in  3  sprite index; values >= N_SPRITES are accepted and discarded
cfg_dx  in  5  signed x velocity
cfg_dy  in  5  signed y velocity
pos_x  out  10*N_SPRITES  flattened left edges, sprite i at [10i+9:10i]
pos_y  out  10*N_SPRITES  flattened top edges
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at sweep end
overrun  out  1  sticky: frame_tick arrived while busy

Behaviour:
- Reset values (asynchronous):
  - x_i = i*(SIZE+16), y_i = i*32.
  - dx_i = +SPEED; dy_i = +SPEED for even i, -SPEED for odd i.
  - FSM in IDLE, idx=0, busy=0, done=0, overrun=0.
- Reset asserted mid-sweep: everything returns to reset values immediately. No partial write-back survives.
- FSM states: IDLE, CALC, WRITE, DONE.
  - IDLE: frame_tick -> CALC with idx=0.
  - CALC: compute and register the next state of sprite idx -> WRITE.
  - WRITE: commit to the register file. If idx=N_SPRITES-1 -> DONE; else idx+1 -> CALC.
  - DONE: done=1 for one cycle -> IDLE.
- Timing: tick at cycle T gives busy=1 on T+1..T+2N+1 and done on T+2N+1 (T+9 for N=4).
- Arithmetic: 11-bit signed. nx = x + sext(dx). Each axis is handled independently; x and y can both bounce in the same frame.
  - If nx < 0: x <- 0, dx <- +|dx|.
  - Else if nx+SIZE-1 > X_MAX: x <- X_MAX-SIZE+1, dx <- -|dx|.
  - Else x <- nx, dx unchanged.
  - Y axis is identical, using Y_MAX.
  - Zero velocity holds position.
  - |-16| saturates to +15.
- Sprite i outputs change only in its WRITE cycle. Sweeps occur in vblank, so no tearing.
- cfg_ready = (state==IDLE) && !frame_tick. A simultaneous tick wins and the config stalls.
  - On acceptance, dx/dy of cfg_id update next cycle and take effect at the next sweep.
- frame_tick in any state other than IDLE: ignored, overrun set. overrun is cleared only by reset.

Decomposition:
- Shared package (sprite_pkg): FSM state encoding, coordinate width (10), velocity width (5), X_MAX/Y_MAX defaults.
- One natural sub-module: sprite_bounce_alu. Purely combinational; inputs pos, vel, limit, SIZE; outputs next pos, next vel. Instantiated twice (x axis, y axis). Reused by the pixel generator team.

Test Plan:
- Reset, single tick at T → busy on T+1..T+9, done at T+9 only. Sprite 0 becomes (2,2). Sprite 1 goes from (80,32) to (82,30).
- Top wall: 18 ticks → sprite 1 y sequence ends ...,2,0 at tick 16. Tick 17 clamps y=0, dy=+2. Tick 18 gives y=2.
- Right wall: sprite 3 starting at x=240 reaches x=576 at tick 168. Tick 169 holds 576 with dx=-2. Tick 170 gives x=574.
- Config: cfg_id=2, dx=-5, dy=0 accepted in IDLE, then tick → sprite 2 goes from (160,64) to (155,64). cfg_id=6 is accepted and no state changes.
- Config/tick collision: cfg_valid and frame_tick in the same cycle → cfg_ready=0, sweep runs with old velocity, config accepted after done.
- Overrun and mid-sweep reset: second frame_tick at T+4 → overrun=1 and exactly one done pulse. Reset asserted at T+5 → reset positions restored and overrun=0.
